// File: rtl/md4_block_if.sv
// Handshake and data bundle between an MD4 requester and the md4_block core.
interface md4_block_if;
    logic         irdy;
    logic [31:0]  state_a, state_b, state_c, state_d;
    logic [511:0] data;
    logic         ordy;
    logic [31:0]  newstate_a, newstate_b, newstate_c, newstate_d;

    modport master (
        output irdy, state_a, state_b, state_c, state_d, data,
        input  ordy, newstate_a, newstate_b, newstate_c, newstate_d
    );
    modport slave (
        input  irdy, state_a, state_b, state_c, state_d, data,
        output ordy, newstate_a, newstate_b, newstate_c, newstate_d
    );
endinterface

// File: rtl/md4_block.sv
// One MD4 compression per irdy rising edge, one step per clock, result after 49 edges.
module md4_block (
    input  logic        clk,
    input  logic        reset_n,
    md4_block_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state_q;
    logic [5:0]   step_q;
    logic         irdy_q;
    logic         ordy_q;
    logic [31:0]  a_q, b_q, c_q, d_q;
    logic [31:0]  aa_q, bb_q, cc_q, dd_q;
    logic [31:0]  na_q, nb_q, nc_q, nd_q;
    logic [511:0] blk_q;

    logic [1:0]   rnd;
    logic [3:0]   idx, k;
    logic [4:0]   s;
    logic [31:0]  f, kc, xw, sum, a_d;
    logic [63:0]  dbl;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    always_comb begin
        rnd = step_q[5:4];
        idx = step_q[3:0];
        k   = idx;
        s   = 5'd3;
        f   = (b_q & c_q) | (~b_q & d_q);
        kc  = 32'h0;
        case (rnd)
            2'd0: begin
                case (idx[1:0])
                    2'd0: s = 5'd3;
                    2'd1: s = 5'd7;
                    2'd2: s = 5'd11;
                    default: s = 5'd19;
                endcase
            end
            2'd1: begin
                // Column-major word order: 0,4,8,12,1,5,...
                k  = {idx[1:0], idx[3:2]};
                f  = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
                kc = 32'h5A827999;
                case (idx[1:0])
                    2'd0: s = 5'd3;
                    2'd1: s = 5'd5;
                    2'd2: s = 5'd9;
                    default: s = 5'd13;
                endcase
            end
            default: begin
                // Bit-reversed word order: 0,8,4,12,2,...
                k  = {idx[0], idx[1], idx[2], idx[3]};
                f  = b_q ^ c_q ^ d_q;
                kc = 32'h6ED9EBA1;
                case (idx[1:0])
                    2'd0: s = 5'd3;
                    2'd1: s = 5'd9;
                    2'd2: s = 5'd11;
                    default: s = 5'd15;
                endcase
            end
        endcase
        // Word k sits at bits 511-32k down; {~k,5'h1f} is that top index.
        xw  = bswap(blk_q[{~k, 5'h1f} -: 32]);
        sum = a_q + f + xw + kc;
        dbl = {sum, sum} << s;
        a_d = dbl[63:32];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= 6'd0;
            irdy_q  <= 1'b0;
            ordy_q  <= 1'b0;
            na_q    <= 32'h0;
            nb_q    <= 32'h0;
            nc_q    <= 32'h0;
            nd_q    <= 32'h0;
        end else begin
            irdy_q <= bus.irdy;
            case (state_q)
                IDLE: begin
                    if (bus.irdy && !irdy_q) begin
                        a_q     <= bus.state_a;
                        b_q     <= bus.state_b;
                        c_q     <= bus.state_c;
                        d_q     <= bus.state_d;
                        aa_q    <= bus.state_a;
                        bb_q    <= bus.state_b;
                        cc_q    <= bus.state_c;
                        dd_q    <= bus.state_d;
                        blk_q   <= bus.data;
                        step_q  <= 6'd0;
                        ordy_q  <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                default: begin
                    if (step_q == 6'd48) begin
                        na_q    <= a_q + aa_q;
                        nb_q    <= b_q + bb_q;
                        nc_q    <= c_q + cc_q;
                        nd_q    <= d_q + dd_q;
                        ordy_q  <= 1'b1;
                        step_q  <= 6'd0;
                        state_q <= IDLE;
                    end else begin
                        a_q    <= d_q;
                        b_q    <= a_d;
                        c_q    <= b_q;
                        d_q    <= c_q;
                        step_q <= step_q + 6'd1;
                    end
                end
            endcase
        end
    end

    assign bus.ordy       = ordy_q;
    assign bus.newstate_a = na_q;
    assign bus.newstate_b = nb_q;
    assign bus.newstate_c = nc_q;
    assign bus.newstate_d = nd_q;
endmodule

// File: tb/tb_md4_block.sv
// Directed MD4 vectors, latency, hold, back-to-back, reset-abort and irdy-glitch checks.
module tb_md4_block;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    md4_block_if bus();
    md4_block dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [511:0] D_EMPTY = {8'h80, 440'h0, 64'h0};
    localparam logic [511:0] D_TEST  = {32'h74657374, 8'h80, 408'h0, 8'h20, 56'h0};
    localparam logic [511:0] D_REIN  = {128'h7265696E64656572666C6F74696C6C61, 8'h80, 312'h0, 8'h80, 56'h0};
    localparam logic [511:0] D_SWORD = {72'h73776F726466697368, 8'h80, 368'h0, 8'h48, 56'h0};
    localparam logic [127:0] G_EMPTY = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
    localparam logic [127:0] G_TEST  = 128'hDB346D691D7ACC4DC2625DB19F9E3F52;
    localparam logic [127:0] G_REIN  = 128'hDEABAE991701C6BEECB3949552F07601;
    localparam logic [127:0] G_SWORD = 128'h5E2047B913668435800AB70F839F62AB;

    function automatic logic [31:0] bs(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [127:0] to_state(input logic [127:0] g);
        return {bs(g[127:96]), bs(g[95:64]), bs(g[63:32]), bs(g[31:0])};
    endfunction

    function automatic logic [127:0] nstate();
        return {bus.newstate_a, bus.newstate_b, bus.newstate_c, bus.newstate_d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raises irdy (E0 is the next edge), pulses it two cycles, then waits for ordy.
    task automatic run_block(input string tag, input logic [511:0] d, input logic [127:0] g,
                             input bit mutate, input int tog, input int hold);
        int lat;
        logic [127:0] res;
        bus.state_a = 32'h67452301;
        bus.state_b = 32'hEFCDAB89;
        bus.state_c = 32'h98BADCFE;
        bus.state_d = 32'h10325476;
        bus.data    = d;
        bus.irdy    = 1'b1;
        lat = -1;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                bus.irdy = 1'b0;
                if (mutate) begin
                    bus.data    = ~d;
                    bus.state_a = 32'h0;
                end
            end
            if (tog > 1 && lat == tog)     bus.irdy = 1'b1;
            if (tog > 1 && lat == tog + 1) bus.irdy = 1'b0;
            if (bus.ordy === 1'b1 || lat >= 70) break;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd49);
        res = nstate();
        chk({tag, "_state"}, res, to_state(g));
        repeat (hold) @(posedge clk);
        #1;
        chk({tag, "_hold_ordy"}, 128'(bus.ordy), 128'd1);
        chk({tag, "_hold_state"}, nstate(), to_state(g));
    endtask

    initial begin
        int seen;
        reset_n     = 1'b0;
        bus.irdy    = 1'b0;
        bus.state_a = 32'h0;
        bus.state_b = 32'h0;
        bus.state_c = 32'h0;
        bus.state_d = 32'h0;
        bus.data    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ordy", 128'(bus.ordy), 128'd0);
        chk("reset_state", nstate(), 128'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_block("empty", D_EMPTY, G_EMPTY, 1'b0, -1, 5);
        run_block("test",  D_TEST,  G_TEST,  1'b0, -1, 5);
        run_block("rein",  D_REIN,  G_REIN,  1'b0, -1, 0);
        // Starts while ordy is still high; inputs scrambled after E0.
        run_block("sword_b2b", D_SWORD, G_SWORD, 1'b1, -1, 3);
        // irdy re-pulsed mid-run; a second run would drop ordy during the hold.
        run_block("toggle", D_TEST, G_TEST, 1'b0, 10, 60);

        // Abort at step 20.
        bus.data = D_REIN;
        bus.irdy = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        bus.irdy = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        chk("abort_ordy", 128'(bus.ordy), 128'd0);
        chk("abort_state", nstate(), 128'h0);
        reset_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (bus.ordy !== 1'b0) seen++;
        end
        chk("abort_no_ordy", 128'(seen), 128'd0);
        run_block("after_abort", D_REIN, G_REIN, 1'b0, -1, 2);

        // irdy already high while in reset: reset wins, release then starts a run.
        reset_n  = 1'b0;
        bus.irdy = 1'b1;
        @(posedge clk); #1;
        chk("reset_prio_ordy", 128'(bus.ordy), 128'd0);
        reset_n = 1'b1;
        run_block("irdy_held_reset", D_SWORD, G_SWORD, 1'b0, -1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md4_block.md
MD4_BLOCK -- requirements
Module: md4_block

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock, sole timing reference.
REQ-003 Port: reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port: irdy  input  1  start request; a 0->1 transition requests processing of one block.
REQ-005 Port: state_a, state_b, state_c, state_d  input  32 each  chaining values A..D in MD4 numeric form.
REQ-006 Port: data  input  512  message block; message byte 0 in data[511:504], byte 63 in data[7:0].
REQ-007 Port: ordy  output  1  result-valid flag.
REQ-008 Port: newstate_a, newstate_b, newstate_c, newstate_d  output  32 each  updated chaining values.

Function
REQ-009 The block SHALL compute one MD4 compression (RFC 1320) of data onto state_a..d and output A+AA, B+BB, C+CC, D+DD, each modulo 2^32.
REQ-010 Message word X[i] (i=0..15) SHALL be little-endian: X[i] = byteswap32(data[511-32i -: 32]).
REQ-011 Start condition: irdy=1 on the current edge, irdy=0 on the previous edge, and block IDLE.
REQ-012 On the start edge (E0), the block SHALL capture state_a..d and data, load the working registers, clear ordy and enter BUSY.
REQ-013 Inputs SHALL be ignored after E0; they may change freely while the block is BUSY.
REQ-014 On edges E1..E48 the block SHALL execute exactly one MD4 step per edge: a' = rol(a + f(b,c,d) + X[k] + K, s); then (a,b,c,d) <= (d,a',b,c).
REQ-015 Steps 1-16: f=(b&c)|(~b&d), K=0, k=0..15 in order, s cycles 3,7,11,19.
REQ-016 Steps 17-32: f=(b&c)|(b&d)|(c&d), K=32'h5A827999, k=0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, s cycles 3,5,9,13.
REQ-017 Steps 33-48: f=b^c^d, K=32'h6ED9EBA1, k=0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, s cycles 3,9,11,15.
REQ-018 On E49 the block SHALL write the final sums to newstate_a..d, set ordy=1 and return to IDLE.
REQ-019 Latency SHALL be fixed: ordy first reads 1 after E49, which is 49 cycles after the start edge.
REQ-020 ordy and newstate_* SHALL hold their values until the next start edge or reset.
REQ-021 ordy SHALL be 0 from E0 through E48, so a stale result is never flagged valid during a new run.
REQ-022 A rising edge on irdy while BUSY SHALL be ignored; the run in progress continues unaffected.
REQ-023 Holding irdy high for any number of cycles SHALL start exactly one run.
REQ-024 All arithmetic SHALL be 32-bit modulo 2^32, and rotation SHALL be circular left.

Reset
REQ-025 While reset_n=0 at an edge: ordy=0, newstate_a..d=0, state IDLE, step counter=0, previous-irdy register=0.
REQ-026 Reset asserted mid-run SHALL abort the run; no ordy pulse follows.
REQ-027 After reset is released, irdy already high SHALL count as a rising edge and start a run.
REQ-028 Reset SHALL take priority over a start condition occurring on the same edge.

Verification
REQ-029 Empty message: state = 67452301/EFCDAB89/98BADCFE/10325476, data={8'h80,440'h0,64'h0}, irdy pulsed high for 2 cycles -> ordy=1 after 49 cycles; newstate = E0CFD631/31E96AD1/D7593CB7/C089C0E0, i.e. byteswapped digest 31D6CFE0D16AE931B73C59D7E0C089C0.
REQ-030 "test": data={32'h74657374,8'h80,408'h0,8'h20,56'h0}, same initial state -> byteswapped digest DB346D691D7ACC4DC2625DB19F9E3F52.
REQ-031 "reindeerflotilla": data={128'h7265696E64656572666C6F74696C6C61,8'h80,312'h0,8'h80,56'h0} -> digest DEABAE991701C6BEECB3949552F07601; "swordfish": data={72'h73776F726466697368,8'h80,368'h0,8'h48,56'h0} -> digest 5E2047B913668435800AB70F839F62AB.
REQ-032 Back-to-back runs: run 2 starts while ordy=1 from run 1 -> ordy=0 on the next cycle and stays 0 for 48 cycles; data changed at E1 does not alter the result.
REQ-033 Reset at step 20 -> ordy=0 and newstate=0 immediately; no ordy follows; a new irdy rising edge gives a correct result.
REQ-034 irdy toggled at step 10 of a run -> result and latency are unchanged, and no second run occurs.
